// File: rtl/setting_display_if.sv
// Settings-menu display bus: inputs from the settings FSM, tube/LED pin outputs.
// The master side drives the setting; the slave side (the display controller) drives the pins.
interface setting_display_if #(
  parameter int VAL_W     = 8,
  parameter int NUM_TUBES = 8
);
  logic [1:0]           cur_set;
  logic [VAL_W-1:0]     value;
  logic                 blink_en;
  logic [7:0]           seg_out;
  logic [NUM_TUBES-1:0] seg_en;
  logic                 bcd_busy;
  logic [VAL_W-1:0]     led;

  modport master (output cur_set, value, blink_en, input seg_out, seg_en, bcd_busy, led);
  modport slave  (input cur_set, value, blink_en, output seg_out, seg_en, bcd_busy, led);
endinterface

// File: rtl/setting_display_ctrl.sv
// Multiplexed 7-segment driver: 3-char mode label plus a blinking decimal value from a
// sequential double-dabble engine. Define SETTING_LZB_EN for leading-zero blanking.
module setting_display_ctrl #(
  parameter int VAL_W      = 8,
  parameter int VAL_DIGITS = 3,
  parameter int NUM_TUBES  = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  setting_display_if.slave  bus
);
  localparam int BCD_W   = 4 * VAL_DIGITS;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int IDX_W   = $clog2(NUM_TUBES);
  localparam int CNT_W   = $clog2(VAL_W + 1);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_TUBES - 1);
  localparam logic [CNT_W-1:0]   SHIFT_LAST = CNT_W'(VAL_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

  bcd_state_e           state_q, state_d;
  logic [VAL_W-1:0]     latched_q, latched_d;
  logic [VAL_W-1:0]     bin_work_q, bin_work_d;
  logic [BCD_W-1:0]     bcd_work_q, bcd_work_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic [CNT_W-1:0]     shift_cnt_q, shift_cnt_d;
  logic                 busy_q, busy_d;
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 hidden_q, hidden_d;
  logic [1:0]           cur_set_q, cur_set_d;
  logic [7:0]           seg_out_q, seg_out_d;
  logic [NUM_TUBES-1:0] seg_en_q, seg_en_d;

  logic [BCD_W+VAL_W-1:0] shifted;
  logic [VAL_DIGITS-1:0]  lz_blank;
  logic                   upper_zero;
  logic                   value_hidden;
  logic [7:0]             slot_glyph;
  logic                   slot_on;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;  4'd3: return 8'hB0;
      4'd4: return 8'h99;  4'd5: return 8'h92;  4'd6: return 8'h82;  4'd7: return 8'hF8;
      4'd8: return 8'h80;  4'd9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] label_glyph(input logic [1:0] sel, input int pos);
    case (sel)
      2'd0:    return (pos == 0) ? 8'hC7 : 8'h8C;                            // L P P
      2'd1:    return (pos == 0) ? 8'h92 : (pos == 1) ? 8'hF1 : 8'hA1;      // S J d
      2'd2:    return (pos == 0) ? 8'h92 : (pos == 1) ? 8'hC0 : 8'h8C;      // S 0 P
      default: return (pos == 0) ? 8'hC2 : (pos == 1) ? 8'h86 : 8'hC8;      // G E N
    endcase
  endfunction

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < VAL_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign bus.led      = bus.value;
  assign bus.seg_out  = seg_out_q;
  assign bus.seg_en   = seg_en_q;
  assign bus.bcd_busy = busy_q;

  // Binary-to-BCD engine; the display register only ever takes a finished result.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    latched_d   = latched_q;
    bin_work_d  = bin_work_q;
    bcd_work_d  = bcd_work_q;
    disp_d      = disp_q;
    shift_cnt_d = shift_cnt_q;
    busy_d      = busy_q;
    shifted     = {dabble_adjust(bcd_work_q), bin_work_q} << 1;
    case (state_q)
      IDLE: if (bus.value != latched_q) begin
        latched_d   = bus.value;
        bin_work_d  = bus.value;
        bcd_work_d  = '0;
        shift_cnt_d = '0;
        busy_d      = 1'b1;
        state_d     = SHIFT;
      end
      SHIFT: begin
        bcd_work_d  = shifted[BCD_W+VAL_W-1:VAL_W];
        bin_work_d  = shifted[VAL_W-1:0];
        shift_cnt_d = shift_cnt_q + 1'b1;
        if (shift_cnt_q == SHIFT_LAST) state_d = DONE;
      end
      default: begin
        disp_d  = bcd_work_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
`ifdef SETTING_LZB_EN
    for (int i = VAL_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      lz_blank[i] = (i > 0) && upper_zero;
    end
`endif
  end

  // Blink phase restarts visible whenever blinking is off or the mode changes.
  always_comb begin
    cur_set_d   = bus.cur_set;
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;
    if (!bus.blink_en || (bus.cur_set != cur_set_q)) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      hidden_d    = !hidden_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  assign value_hidden = bus.blink_en && hidden_q;

  always_comb begin
    slot_glyph = 8'hFF;
    slot_on    = 1'b0;
    for (int i = 0; i < VAL_DIGITS; i++)
      if (index_q == IDX_W'(i)) begin
        slot_glyph = digit_glyph(disp_q[4*i +: 4]);
        slot_on    = !value_hidden && !lz_blank[i];
      end
    for (int p = 0; p < 3; p++)
      if (index_q == IDX_W'(VAL_DIGITS + p)) begin
        slot_glyph = label_glyph(bus.cur_set, p);
        slot_on    = 1'b1;
      end
    if (index_q == IDX_LAST) begin
      slot_glyph = 8'h92;
      slot_on    = 1'b1;
    end
    if (!slot_on) slot_glyph = 8'hFF;
  end

  // Segments and enables load together on the slot boundary, so tubes never ghost.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    index_d    = index_q;
    seg_out_d  = seg_out_q;
    seg_en_d   = seg_en_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      index_d    = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
      seg_out_d  = slot_glyph;
      seg_en_d   = slot_on ? ~(NUM_TUBES'(1) << index_q) : '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      latched_q   <= '0;
      bin_work_q  <= '0;
      bcd_work_q  <= '0;
      disp_q      <= '0;
      shift_cnt_q <= '0;
      busy_q      <= 1'b0;
      scan_cnt_q  <= '0;
      index_q     <= '0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      cur_set_q   <= '0;
      seg_out_q   <= 8'hFF;
      seg_en_q    <= '1;
    end else begin
      state_q     <= state_d;
      latched_q   <= latched_d;
      bin_work_q  <= bin_work_d;
      bcd_work_q  <= bcd_work_d;
      disp_q      <= disp_d;
      shift_cnt_q <= shift_cnt_d;
      busy_q      <= busy_d;
      scan_cnt_q  <= scan_cnt_d;
      index_q     <= index_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      cur_set_q   <= cur_set_d;
      seg_out_q   <= seg_out_d;
      seg_en_q    <= seg_en_d;
    end
  end
endmodule

// File: tb/tb_setting_display_ctrl.sv
// Directed bench for setting_display_ctrl with SCAN_DIV=4 and BLINK_DIV=16; expectations
// follow the SETTING_LZB_EN build option.
module tb_setting_display_ctrl;
  localparam int VAL_W      = 8;
  localparam int VAL_DIGITS = 3;
  localparam int NUM_TUBES  = 8;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  setting_display_if #(.VAL_W(VAL_W), .NUM_TUBES(NUM_TUBES)) bus ();

  setting_display_ctrl #(
    .VAL_W(VAL_W), .VAL_DIGITS(VAL_DIGITS), .NUM_TUBES(NUM_TUBES),
    .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bad_glyph = 0;
  logic mon_en = 1'b0;
  logic [7:0] fr_seg [8];
  logic [7:0] fr_en  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] en_mask(input int k);
    return ~(8'b1 << k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Slot k output registers load at edges where cyc%4==0, with slot = (cyc/4 - 1) mod 8.
  task automatic wait_mod(input int m, input int r);
    for (int i = 0; i < m && (cyc % m) != r; i++) tick();
  endtask

  task automatic read_frame();
    wait_mod(32, 4);
    for (int k = 0; k < 8; k++) begin
      fr_seg[k] = bus.seg_out;
      fr_en[k]  = bus.seg_en;
      if (k < 7) repeat (4) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.bcd_busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, bus.bcd_busy, 1'b0);
  endtask

  // Only old (005), intermediate (010) and final (200) digit glyphs may appear while converting.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (bus.seg_en == en_mask(k)) begin
          case (k)
            0: if (bus.seg_out != 8'h92 && bus.seg_out != 8'hC0) bad_glyph++;
            1: if (bus.seg_out != 8'hC0 && bus.seg_out != 8'hF9) bad_glyph++;
            default: if (bus.seg_out != 8'hC0 && bus.seg_out != 8'hA4) bad_glyph++;
          endcase
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_seg [8];
    int n;
`ifdef SETTING_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    rst_n        = 1'b0;
    bus.cur_set  = 2'd0;
    bus.value    = '0;
    bus.blink_en = 1'b0;

    // 1: reset state, then first tube enabled on the 4th clock
    repeat (3) @(posedge clk);
    #1;
    check("t1_rst_seg_en", bus.seg_en, 8'hFF);
    check("t1_rst_seg_out", bus.seg_out, 8'hFF);
    check("t1_rst_busy", bus.bcd_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) tick();
    check("t1_pre_en", bus.seg_en, 8'hFF);
    tick();
    check("t1_tube0_en", bus.seg_en, 8'hFE);
    check("t1_tube0_seg", bus.seg_out, 8'hC0);
    check("t1_led", bus.led, 8'd0);

    // 2: value 137, players label
    bus.value = 8'd137;
    n = 0;
    tick();
    while (bus.bcd_busy && n < 50) begin
      n++;
      tick();
    end
    check("t2_busy_cycles", n, 9);
    check("t2_led", bus.led, 8'd137);
    exp_seg = '{8'hF8, 8'hB0, 8'hF9, 8'hC7, 8'h8C, 8'h8C, 8'hFF, 8'h92};
    read_frame();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_seg%0d", k), fr_seg[k], exp_seg[k]);
      check($sformatf("t2_en%0d", k), fr_en[k], (k == 6) ? 8'hFF : en_mask(k));
    end

    // 3: value 5, leading zeros per build option
    bus.value = 8'd5;
    tick();
    wait_idle("t3_idle");
    read_frame();
    check("t3_seg0", fr_seg[0], 8'h92);
    check("t3_en0", fr_en[0], 8'hFE);
    check("t3_seg1", fr_seg[1], LZB ? 8'hFF : 8'hC0);
    check("t3_en1", fr_en[1], LZB ? 8'hFF : 8'hFD);
    check("t3_seg2", fr_seg[2], LZB ? 8'hFF : 8'hC0);
    check("t3_en2", fr_en[2], LZB ? 8'hFF : 8'hFB);

    // 5: change 10 -> 200 while busy
    bus.value = 8'd10;
    tick();
    check("t5_busy", bus.bcd_busy, 1'b1);
    tick();
    tick();
    bus.value = 8'd200;
    mon_en = 1'b1;
    n = 0;
    while (bus.bcd_busy && n < 50) begin
      tick();
      n++;
    end
    check("t5_first_done", bus.bcd_busy, 1'b0);
    tick();
    check("t5_redetect", bus.bcd_busy, 1'b1);
    wait_idle("t5_idle");
    read_frame();
    mon_en = 1'b0;
    check("t5_seg0", fr_seg[0], 8'hC0);
    check("t5_seg1", fr_seg[1], 8'hC0);
    check("t5_seg2", fr_seg[2], 8'hA4);
    check("t5_glyphs", bad_glyph, 0);

    // 4: blinking value field, labels stay lit
    wait_mod(32, 16);
    bus.blink_en = 1'b1;
    wait_mod(32, 4);
    check("t4_hid_en0", bus.seg_en, 8'hFF);
    check("t4_hid_seg0", bus.seg_out, 8'hFF);
    repeat (4) tick();
    check("t4_hid_en1", bus.seg_en, 8'hFF);
    wait_mod(32, 16);
    check("t4_label_seg", bus.seg_out, 8'hC7);
    check("t4_label_en", bus.seg_en, 8'hF7);
    wait_mod(32, 4);
    check("t4_hid2_en0", bus.seg_en, 8'hFF);
    bus.blink_en = 1'b0;
    repeat (4) tick();
    check("t4_off_seg1", bus.seg_out, 8'hC0);
    check("t4_off_en1", bus.seg_en, 8'hFD);
    bus.blink_en = 1'b1;
    repeat (4) tick();
    check("t4_reen_seg2", bus.seg_out, 8'hA4);
    check("t4_reen_en2", bus.seg_en, 8'hFB);
    bus.blink_en = 1'b0;

    // mode change: negative label G E N
    bus.cur_set = 2'd3;
    read_frame();
    check("tm_seg3", fr_seg[3], 8'hC2);
    check("tm_seg4", fr_seg[4], 8'h86);
    check("tm_seg5", fr_seg[5], 8'hC8);
    check("tm_seg7", fr_seg[7], 8'h92);

    // 6: reset during a conversion, then 42
    bus.value = 8'd123;
    tick();
    tick();
    tick();
    check("t6_busy", bus.bcd_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_seg", bus.seg_out, 8'hFF);
    check("t6_rst_en", bus.seg_en, 8'hFF);
    check("t6_rst_busy", bus.bcd_busy, 1'b0);
    bus.value   = 8'd42;
    bus.cur_set = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    wait_idle("t6_idle");
    read_frame();
    check("t6_seg0", fr_seg[0], 8'hA4);
    check("t6_en0", fr_en[0], 8'hFE);
    check("t6_seg1", fr_seg[1], 8'h99);
    check("t6_seg2", fr_seg[2], LZB ? 8'hFF : 8'hC0);
    check("t6_en2", fr_en[2], LZB ? 8'hFF : 8'hFB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
